parking_management: RTL and testbench
=====================================

// Module: parking_management
// PURPOSE
//  Occupancy controller for a 700-space car park shared by university (uni) and
//  public (non-uni) cars. Tracks parked cars per category and computes free spaces
//  against an hour-dependent capacity split. Reports whether each category can
//  accept a car. Sits between the gate/sensor front-end and the display/barrier logic.
// PARAMETERS
//  TOTAL_CAP   700  total spaces; uni capacity + non-uni capacity always equals this
//  UNI_CAP_DAY 500  uni capacity for hours below 13
//  CAP_STEP    50   uni capacity reduction per hour, hours 13..15
//  UNI_CAP_EVE 200  uni capacity for hour 16 and later
// PORTS
//  clk                  in   1   system clock, all state on rising edge
//  rst_n                in   1   asynchronous active-low reset
//  current_hour         in   5   hour of day, 0..23 (values >23 are treated as >=16)
//  car_entered          in   1   entry event request (level pulse, any width)
//  is_uni_car_entered   in   1   entry category: 1 = uni, 0 = non-uni
//  car_exited           in   1   exit event request (level pulse, any width)
//  is_uni_car_exited    in   1   exit category: 1 = uni, 0 = non-uni
//  uni_parked_car       out  10  uni cars currently parked
//  parked_car           out  10  non-uni cars currently parked
//  uni_vacated_space    out  10  free uni spaces
//  vacated_space        out  10  free non-uni spaces
//  uni_is_vacated_space out  1   1 when uni_vacated_space > 0
//  is_vacated_space     out  1   1 when vacated_space > 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): both counters 0, both edge-detect registers 0.
//    Outputs then read uni_vacated 500, vacated 200, both flags 1 (hour<13).
//  - Capacity split, combinational from current_hour:
//    hour<=12: uni 500 / non-uni 200; 13: 450/250; 14: 400/300;
//    15: 350/350; >=16: 200/500.
//  - Events: each rising edge of car_entered / car_exited counts exactly once,
//    detected against a registered copy of the input. Pulse width is irrelevant.
//    The counter updates on the clock edge that samples the 0->1 transition.
//    Category inputs are sampled on that same edge.
//  - Entry is accepted only if that category's free space > 0. Otherwise it is
//    ignored and the counter is unchanged.
//  - Exit decrements the category counter only if it is > 0. Exit at 0 is ignored.
//  - Simultaneous entry and exit in one cycle:
//    - Exit is evaluated first. Entry is then checked against the post-exit count.
//    - Same category with counter full: net change 0, entry accepted.
//    - Different categories: each is applied independently.
//  - Free space = capacity - parked, saturating at 0. This covers a capacity drop
//    below the current occupancy, e.g. 499 uni cars at hour 16 gives 0, not negative.
//    Cars are never evicted; counters are only changed by events.
//  - Outputs are combinational from counters and current_hour, so there is no extra
//    latency. Counter value is visible one clock after the detected edge.
//  - Counters never exceed TOTAL_CAP and fit in 10 bits; no wrap-around possible.
// TESTING
//  1 reset, hour 8 -> parked 0/0, uni_vacated 500, vacated 200, flags 1/1
//  2 hour 8, 470 uni entry pulses -> uni_parked 470, uni_vacated 30, flag 1
//  3 continue to 500 uni, 1 more uni entry -> uni_parked stays 500,
//    uni_vacated 0, uni flag 0; then 1 uni exit -> 499, uni_vacated 1
//  4 hour 13, 1 non-uni entry -> parked 1, vacated 249; hour 16 with 499 uni ->
//    uni_vacated 0, uni flag 0, uni entry rejected, vacated 499
//  5 non-uni exit at parked 0 -> stays 0; one entry pulse held 5 clocks -> +1 only
//  6 simultaneous uni exit + non-uni entry -> uni -1, non-uni +1;
//    assert rst_n mid-run -> all counters 0 immediately

Source files
------------

// File: rtl/parking_management.sv
// Occupancy controller for a shared uni / public car park.
// Counts parked cars per category against an hour-dependent capacity split.
module parking_management #(
  parameter int unsigned TOTAL_CAP   = 700,
  parameter int unsigned UNI_CAP_DAY = 500,
  parameter int unsigned CAP_STEP    = 50,
  parameter int unsigned UNI_CAP_EVE = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] current_hour,
  input  logic       car_entered,
  input  logic       is_uni_car_entered,
  input  logic       car_exited,
  input  logic       is_uni_car_exited,
  output logic [9:0] uni_parked_car,
  output logic [9:0] parked_car,
  output logic [9:0] uni_vacated_space,
  output logic [9:0] vacated_space,
  output logic       uni_is_vacated_space,
  output logic       is_vacated_space
);

  localparam logic [9:0] TOTAL   = 10'(TOTAL_CAP);
  localparam logic [9:0] UNI_DAY = 10'(UNI_CAP_DAY);
  localparam logic [9:0] STEP    = 10'(CAP_STEP);
  localparam logic [9:0] UNI_EVE = 10'(UNI_CAP_EVE);

  logic [9:0] uni_cap;
  logic [9:0] non_cap;
  logic [9:0] uni_cnt;
  logic [9:0] non_cnt;
  logic [9:0] uni_post_exit;
  logic [9:0] non_post_exit;
  logic [9:0] uni_next;
  logic [9:0] non_next;
  logic       entered_q;
  logic       exited_q;
  logic       entry_rise;
  logic       exit_rise;

  always_comb begin
    uni_cap = UNI_EVE;
    if (current_hour <= 5'd12)
      uni_cap = UNI_DAY;
    else if (current_hour == 5'd13)
      uni_cap = UNI_DAY - STEP;
    else if (current_hour == 5'd14)
      uni_cap = UNI_DAY - (STEP << 1);
    else if (current_hour == 5'd15)
      uni_cap = UNI_DAY - (STEP * 10'd3);
    non_cap = TOTAL - uni_cap;
  end

  assign entry_rise = car_entered & ~entered_q;
  assign exit_rise  = car_exited  & ~exited_q;

  // Exit is applied first so a same-cycle entry sees the freed space.
  always_comb begin
    uni_post_exit = uni_cnt;
    non_post_exit = non_cnt;
    if (exit_rise) begin
      if (is_uni_car_exited) begin
        if (uni_cnt != '0) uni_post_exit = uni_cnt - 10'd1;
      end else begin
        if (non_cnt != '0) non_post_exit = non_cnt - 10'd1;
      end
    end
    uni_next = uni_post_exit;
    non_next = non_post_exit;
    if (entry_rise) begin
      if (is_uni_car_entered) begin
        if (uni_post_exit < uni_cap) uni_next = uni_post_exit + 10'd1;
      end else begin
        if (non_post_exit < non_cap) non_next = non_post_exit + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uni_cnt   <= '0;
      non_cnt   <= '0;
      entered_q <= 1'b0;
      exited_q  <= 1'b0;
    end else begin
      uni_cnt   <= uni_next;
      non_cnt   <= non_next;
      entered_q <= car_entered;
      exited_q  <= car_exited;
    end
  end

  // Saturate: capacity may drop below current occupancy when the hour changes.
  assign uni_vacated_space    = (uni_cnt >= uni_cap) ? '0 : uni_cap - uni_cnt;
  assign vacated_space        = (non_cnt >= non_cap) ? '0 : non_cap - non_cnt;
  assign uni_is_vacated_space = (uni_vacated_space != '0);
  assign is_vacated_space     = (vacated_space != '0);
  assign uni_parked_car       = uni_cnt;
  assign parked_car           = non_cnt;

endmodule

// File: tb/tb_parking_management.sv
// Bench for parking_management: occupancy model plus directed scenarios.
module tb_parking_management;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] current_hour = 5'd8;
  logic       car_entered = 1'b0;
  logic       is_uni_car_entered = 1'b0;
  logic       car_exited = 1'b0;
  logic       is_uni_car_exited = 1'b0;
  logic [9:0] uni_parked_car;
  logic [9:0] parked_car;
  logic [9:0] uni_vacated_space;
  logic [9:0] vacated_space;
  logic       uni_is_vacated_space;
  logic       is_vacated_space;

  int total = 0;
  int bad   = 0;

  parking_management #(
    .TOTAL_CAP  (700),
    .UNI_CAP_DAY(500),
    .CAP_STEP   (50),
    .UNI_CAP_EVE(200)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .current_hour        (current_hour),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .uni_parked_car      (uni_parked_car),
    .parked_car          (parked_car),
    .uni_vacated_space   (uni_vacated_space),
    .vacated_space       (vacated_space),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space    (is_vacated_space)
  );

  always #5 clk = ~clk;

  function automatic int uni_cap_of(input int h);
    if (h <= 12) return 500;
    if (h <= 15) return 500 - 50 * (h - 12);
    return 200;
  endfunction

  function automatic int free_of(input int cap, input int n);
    return (cap > n) ? cap - n : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference occupancy: counts of cars per category, updated by rising events.
  int m_uni = 0;
  int m_non = 0;
  bit m_ent_q = 1'b0;
  bit m_ext_q = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int u, n, cap;
    if (!rst_n) begin
      m_uni   <= 0;
      m_non   <= 0;
      m_ent_q <= 1'b0;
      m_ext_q <= 1'b0;
    end else begin
      u   = m_uni;
      n   = m_non;
      cap = uni_cap_of(int'(current_hour));
      if (car_exited && !m_ext_q) begin
        if (is_uni_car_exited) begin
          if (u > 0) u = u - 1;
        end else if (n > 0) begin
          n = n - 1;
        end
      end
      if (car_entered && !m_ent_q) begin
        if (is_uni_car_entered) begin
          if (u < cap) u = u + 1;
        end else if (n < 700 - cap) begin
          n = n + 1;
        end
      end
      m_uni   <= u;
      m_non   <= n;
      m_ent_q <= car_entered;
      m_ext_q <= car_exited;
    end
  end

  always @(negedge clk) begin
    int cap;
    #2;
    cap = uni_cap_of(int'(current_hour));
    check("m_uni_parked", int'(uni_parked_car), m_uni);
    check("m_parked", int'(parked_car), m_non);
    check("m_uni_vac", int'(uni_vacated_space), free_of(cap, m_uni));
    check("m_vac", int'(vacated_space), free_of(700 - cap, m_non));
    check("m_uni_flag", int'(uni_is_vacated_space), int'(free_of(cap, m_uni) > 0));
    check("m_flag", int'(is_vacated_space), int'(free_of(700 - cap, m_non) > 0));
  end

  task automatic ev(input bit e, input bit eu, input bit x, input bit xu, input int hold);
    @(negedge clk);
    car_entered        = e;
    is_uni_car_entered = eu;
    car_exited         = x;
    is_uni_car_exited  = xu;
    repeat (hold) @(negedge clk);
    car_entered = 1'b0;
    car_exited  = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    current_hour = 5'd8;
    repeat (2) @(negedge clk);
    #2;
    check("rst_uni_parked", int'(uni_parked_car), 0);
    check("rst_parked", int'(parked_car), 0);
    check("rst_uni_vac", int'(uni_vacated_space), 500);
    check("rst_vac", int'(vacated_space), 200);
    check("rst_uni_flag", int'(uni_is_vacated_space), 1);
    check("rst_flag", int'(is_vacated_space), 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 470; i++) ev(1'b1, 1'b1, 1'b0, 1'b0, 1);
    settle();
    check("fill470_parked", int'(uni_parked_car), 470);
    check("fill470_vac", int'(uni_vacated_space), 30);
    check("fill470_flag", int'(uni_is_vacated_space), 1);

    for (int i = 0; i < 31; i++) ev(1'b1, 1'b1, 1'b0, 1'b0, 1);
    settle();
    check("full_parked", int'(uni_parked_car), 500);
    check("full_vac", int'(uni_vacated_space), 0);
    check("full_flag", int'(uni_is_vacated_space), 0);

    ev(1'b0, 1'b0, 1'b1, 1'b1, 1);
    settle();
    check("exit_parked", int'(uni_parked_car), 499);
    check("exit_vac", int'(uni_vacated_space), 1);

    // Full uni, same-category exit and entry together: net zero.
    ev(1'b1, 1'b1, 1'b0, 1'b0, 1);
    ev(1'b1, 1'b1, 1'b1, 1'b1, 1);
    settle();
    check("swap_full_parked", int'(uni_parked_car), 500);
    ev(1'b0, 1'b0, 1'b1, 1'b1, 1);

    @(negedge clk);
    current_hour = 5'd13;
    ev(1'b1, 1'b0, 1'b0, 1'b0, 1);
    settle();
    check("h13_parked", int'(parked_car), 1);
    check("h13_vac", int'(vacated_space), 249);

    @(negedge clk);
    current_hour = 5'd16;
    settle();
    check("h16_uni_vac", int'(uni_vacated_space), 0);
    check("h16_uni_flag", int'(uni_is_vacated_space), 0);
    check("h16_vac", int'(vacated_space), 499);
    ev(1'b1, 1'b1, 1'b0, 1'b0, 1);
    settle();
    check("h16_reject", int'(uni_parked_car), 499);

    @(negedge clk);
    current_hour = 5'd31;
    settle();
    check("h31_uni_vac", int'(uni_vacated_space), 0);
    check("h31_vac", int'(vacated_space), 499);

    @(negedge clk);
    current_hour = 5'd8;
    ev(1'b0, 1'b0, 1'b1, 1'b0, 1);
    ev(1'b0, 1'b0, 1'b1, 1'b0, 1);
    settle();
    check("exit_at_zero", int'(parked_car), 0);
    ev(1'b1, 1'b0, 1'b0, 1'b0, 5);
    settle();
    check("held_pulse", int'(parked_car), 1);

    ev(1'b1, 1'b0, 1'b1, 1'b1, 1);
    settle();
    check("mixed_uni", int'(uni_parked_car), 498);
    check("mixed_non", int'(parked_car), 2);

    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_uni", int'(uni_parked_car), 0);
    check("midrst_non", int'(parked_car), 0);
    check("midrst_uni_vac", int'(uni_vacated_space), 500);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
